// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the PC and applies same-cycle or pending redirects on each accepted imem fetch.
// Latency: a redirect reaches pc/imem_addr one cycle after its accepting ack; the first fetch is issued two edges after reset release.
// Backpressure: imem_ack low holds the fetch in place; stall parks the sequencer with imem_req low and pc frozen.
// Optional build macro PCSEQ_ALIGN_CHECK_EN: reject (rather than realign) redirect targets whose low two bits are non-zero.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       pcsrc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             stall,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             misaligned
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             run_en;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pend_pc;
    logic             pend_valid;
    logic             flush_q;
    logic [WIDTH-1:0] sel_tgt;
    logic [WIDTH-1:0] jump_tgt;
    logic [WIDTH-1:0] tgt;
    logic [27:0]      jfield;
    logic             redir_sel;
    logic             redir_take;
    logic             ack_acc;

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + WIDTH'(4);

    // J-type target keeps the region bits of the next sequential PC
    assign jfield = {jump_index, 2'b00};
    if (WIDTH > 28) begin : g_jwide
        assign jump_tgt = {pc_plus4[WIDTH-1:28], jfield};
    end else begin : g_jnarrow
        assign jump_tgt = jfield[WIDTH-1:0];
    end

    // Select the candidate redirect target from the pcsrc code
    always_comb begin
        sel_tgt = branch_target;
        case (pcsrc)
            2'b10:   sel_tgt = jump_tgt;
            2'b11:   sel_tgt = jr_target;
            default: sel_tgt = branch_target;
        endcase
    end

    assign redir_sel = redirect_valid && (pcsrc != 2'b00);
    assign ack_acc   = (state == FETCH) && imem_ack && !stall;

`ifdef PCSEQ_ALIGN_CHECK_EN
    logic tgt_misal;
    logic misal_q;

    assign tgt_misal  = (sel_tgt[1:0] != 2'b00);
    assign tgt        = sel_tgt;
    assign redir_take = redir_sel && !tgt_misal;
    assign misaligned = misal_q;

    // Pulse once for every qualified redirect whose target is rejected
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misal_q <= 1'b0;
        end else begin
            misal_q <= redir_sel && tgt_misal;
        end
    end
`else
    assign tgt        = sel_tgt & ~WIDTH'(3);
    assign redir_take = redir_sel;
    assign misaligned = 1'b0;
`endif

    // Swallow the first edge after reset release so BOOT spans one full cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: stall parks in HOLD from any state
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    if (run_en) state_nxt = stall ? HOLD : FETCH;
            FETCH:   state_nxt = stall ? HOLD : FETCH;
            HOLD:    state_nxt = stall ? HOLD : FETCH;
            default: state_nxt = BOOT;
        endcase
    end

    // FSM outputs: request is a decode of the registered state
    always_comb begin
        imem_req = (state == FETCH);
    end

    // PC, pending redirect and flush update; an accepted ack consumes the pending slot
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            pend_pc    <= RESET_PC;
            pend_valid <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (ack_acc) begin
                pend_valid <= 1'b0;
                if (redir_take) begin
                    pc_q    <= tgt;
                    flush_q <= 1'b1;
                end else if (pend_valid) begin
                    pc_q    <= pend_pc;
                    flush_q <= 1'b1;
                end else begin
                    pc_q <= pc_plus4;
                end
            end else if (redir_take) begin
                pend_valid <= 1'b1;
                pend_pc    <= tgt;
            end
        end
    end

    assign flush = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed redirect/stall/wrap/reset vectors with a fetch scoreboard.
// Each accepted fetch (req & ack & !stall) is checked against the queued expected pc/flush/misaligned.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_pc_sequencer;

    typedef struct packed {
        logic [31:0] addr;
        logic        flush;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  pcsrc;
    logic        redirect_valid;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        stall;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misaligned;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pcsrc          (pcsrc),
        .redirect_valid (redirect_valid),
        .branch_target  (branch_target),
        .jump_index     (jump_index),
        .jr_target      (jr_target),
        .stall          (stall),
        .imem_ack       (imem_ack),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .flush          (flush),
        .misaligned     (misaligned)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic f, input logic m);
        exp_t e;
        e.addr  = a;
        e.flush = f;
        e.mis   = m;
        sb.push_back(e);
    endtask

    // Monitor: every accepted fetch must match the next queued expectation
    always @(negedge clk) begin
        if (reset_n && imem_req && imem_ack && !stall) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_fetch actual=%h required=none", pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pc", pc, e.addr);
                check("sb_imem_addr", imem_addr, e.addr);
                check("sb_flush", {31'b0, flush}, {31'b0, e.flush});
                check("sb_misaligned", {31'b0, misaligned}, {31'b0, e.mis});
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        pcsrc          = 2'b00;
        redirect_valid = 1'b0;
        branch_target  = '0;
        jump_index     = '0;
        jr_target      = '0;
        stall          = 1'b0;
        imem_ack       = 1'b1;
        #12;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_misaligned", {31'b0, misaligned}, 32'h0);

        // Release with ack tied high: req on edge 2, then 0,4,8 one per cycle
        step();
        reset_n = 1'b1;
        push(32'h0, 1'b0, 1'b0);
        push(32'h4, 1'b0, 1'b0);
        push(32'h8, 1'b0, 1'b0);
        step();
        check("boot_edge1_req", {31'b0, imem_req}, 32'h0);
        step();
        check("boot_edge2_req", {31'b0, imem_req}, 32'h1);
        step();
        step();
        step();
        imem_ack = 1'b0;
        check("seq_pc_hold", pc, 32'hC);

        // Same-cycle jr to 0x100
        pcsrc = 2'b11; redirect_valid = 1'b1; jr_target = 32'h100; imem_ack = 1'b1;
        push(32'hC, 1'b0, 1'b0);
        step();
        redirect_valid = 1'b0; imem_ack = 1'b0;
        check("jr_same_pc", pc, 32'h100);
        check("jr_same_flush", {31'b0, flush}, 32'h1);

        // Pending jr to 0x400 while ack is low for three cycles
        pcsrc = 2'b11; redirect_valid = 1'b1; jr_target = 32'h400;
        step();
        redirect_valid = 1'b0;
        check("pend_pc_held", pc, 32'h100);
        check("pend_no_flush", {31'b0, flush}, 32'h0);
        step();
        step();
        imem_ack = 1'b1;
        push(32'h100, 1'b0, 1'b0);
        step();
        push(32'h400, 1'b1, 1'b0);
        step();
        imem_ack = 1'b0;

        // Pending jump (0x40) overwritten by branch to 0x200
        pcsrc = 2'b10; redirect_valid = 1'b1; jump_index = 26'h10;
        step();
        pcsrc = 2'b01; branch_target = 32'h200;
        step();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        push(32'h404, 1'b0, 1'b0);
        step();
        push(32'h200, 1'b1, 1'b0);
        step();
        imem_ack = 1'b0;

        // Stall two cycles with ack high: request drops, pc frozen
        imem_ack = 1'b1; stall = 1'b1;
        step();
        check("stall1_req", {31'b0, imem_req}, 32'h0);
        check("stall1_pc", pc, 32'h204);
        step();
        check("stall2_req", {31'b0, imem_req}, 32'h0);
        check("stall2_pc", pc, 32'h204);
        stall = 1'b0;
        step();
        push(32'h204, 1'b0, 1'b0);
        check("resume_req", {31'b0, imem_req}, 32'h1);
        check("resume_pc", pc, 32'h204);
        step();
        imem_ack = 1'b0;

        // Wrap from 0xFFFFFFFC to 0
        pcsrc = 2'b11; redirect_valid = 1'b1; jr_target = 32'hFFFF_FFFC; imem_ack = 1'b1;
        push(32'h208, 1'b0, 1'b0);
        step();
        redirect_valid = 1'b0;
        push(32'hFFFF_FFFC, 1'b1, 1'b0);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        step();
        push(32'h0, 1'b0, 1'b0);
        step();
        imem_ack = 1'b0;

        // Reset mid-fetch with a pending branch: pending discarded
        pcsrc = 2'b01; redirect_valid = 1'b1; branch_target = 32'h300;
        step();
        redirect_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0);
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        step();
        reset_n = 1'b1;
        step();
        check("rerst_edge1_req", {31'b0, imem_req}, 32'h0);
        step();
        check("rerst_edge2_req", {31'b0, imem_req}, 32'h1);
        imem_ack = 1'b1;
        push(32'h0, 1'b0, 1'b0);
        step();
        push(32'h4, 1'b0, 1'b0);
        step();
        imem_ack = 1'b0;

        // jr to misaligned 0x402
        pcsrc = 2'b11; redirect_valid = 1'b1; jr_target = 32'h402; imem_ack = 1'b1;
        push(32'h8, 1'b0, 1'b0);
        step();
        redirect_valid = 1'b0;
`ifdef PCSEQ_ALIGN_CHECK_EN
        push(32'hC, 1'b0, 1'b1);
`else
        push(32'h400, 1'b1, 1'b0);
`endif
        step();
        imem_ack = 1'b0;
        step();
        check("sb_drained", sb.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter sequencer sitting directly downstream of the jump/branch PC-source select logic. Consumes its 2-bit `pcsrc` code, the candidate targets, and a stall request. Owns the architectural PC register and drives a req/ack handshake to instruction memory. Queues a redirect that arrives while a fetch is in flight, applies it when that fetch completes, and flags the wrong-path instruction for flushing.

## Interface
- `WIDTH`, 32, address/PC width in bits (≥ 8).
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pcsrc`  in  2  00 = PC+4, 01 = branch, 10 = jump, 11 = jr; only meaningful when `redirect_valid` is 1.
- `redirect_valid`  in  1  qualifies `pcsrc` and the targets this cycle.
- `branch_target`  in  WIDTH  absolute branch target.
- `jump_index`  in  26  J-type index field.
- `jr_target`  in  WIDTH  register value for jr.
- `stall`  in  1  hold PC and suppress fetch.
- `imem_ack`  in  1  instruction memory accepted and returned the current fetch.
- `imem_req`  out  1  fetch request (registered).
- `imem_addr`  out  WIDTH  fetch address; always equals `pc`.
- `pc`  out  WIDTH  current PC.
- `pc_plus4`  out  WIDTH  `pc + 4`, modulo 2^WIDTH, combinational.
- `flush`  out  1  one-cycle pulse: the instruction returned with the last ack is wrong-path.
- `misaligned`  out  1  one-cycle pulse on a rejected target (see Configuration).

## Operation
- Target mux:
  - 01 → `branch_target`
  - 10 → `{pc_plus4[WIDTH-1:28], jump_index, 2'b00}`
  - 11 → `jr_target`
  - 00 with `redirect_valid` = 1 is a no-op; nothing is captured.
- FSM states:
  - BOOT: reset state; `imem_req` = 0; unconditionally → FETCH next cycle (→ HOLD if `stall`).
  - FETCH: `imem_req` = 1, awaiting `imem_ack`.
  - HOLD: `imem_req` = 0; PC frozen; → FETCH the cycle after `stall` falls.
- FETCH with `stall` = 1 → HOLD. `imem_ack` in that same cycle is ignored; the fetch is re-issued later.
- Pending redirect: `pend_valid`/`pend_pc`.
  - Any qualified non-00 redirect in any state loads `pend_pc` and sets `pend_valid`.
  - A newer redirect overwrites an older pending one.
- Accepted ack: FETCH, `imem_ack` = 1, `stall` = 0. Next PC priority:
  1. same-cycle qualified redirect target
  2. `pend_pc`
  3. `pc_plus4`
- When choice 1 or 2 is taken: `flush` = 1 next cycle, `pend_valid` cleared.
- PC increment wraps modulo 2^WIDTH; from all-ones−3 the next PC is 0.
- Async reset, including mid-fetch: `pc` = `RESET_PC`, state BOOT, `pend_valid` = 0.

## Timing
- Reset values: `imem_req` 0, `pc`/`imem_addr` `RESET_PC`, `pc_plus4` `RESET_PC`+4, `flush` 0, `misaligned` 0.
- First `imem_req` = 1: second rising edge after `reset_n` deasserts (BOOT lasts one cycle).
- Ack in the cycle `imem_req` rises is legal. Sustained throughput is one PC per cycle while `imem_ack` is held high.
- Redirect to `imem_addr`: one cycle after the accepting ack edge, whether the redirect was same-cycle or pending.
- `flush` and `misaligned` are registered single-cycle pulses, coincident with the PC update they describe.

## Configuration
- `PCSEQ_ALIGN_CHECK_EN` defined:
  - A selected target with bits [1:0] ≠ 00 is not captured or applied.
  - `misaligned` pulses one cycle after the offending redirect cycle.
  - Sequencing continues as if no redirect arrived; an existing pending redirect is preserved.
- Not defined:
  - Target bits [1:0] are forced to 00 before capture/apply.
  - `misaligned` is tied to 0.

## Test plan
- Reset release, `imem_ack` tied 1 → `imem_req` rises on edge 2; `pc` sequence 0x0, 0x4, 0x8, one per cycle; `flush` stays 0.
- `pc` = 0x100, ack held low 3 cycles, `pcsrc` = 11 + `redirect_valid` with `jr_target` = 0x400 in cycle 1, ack in cycle 4 → `pc` = 0x400 next cycle, `flush` pulses once.
- Pending jump (`jump_index` = 0x10 → 0x40) followed by a branch to 0x200 before the ack → branch wins, `pc` = 0x200.
- `stall` for 2 cycles while `imem_ack` = 1 → `imem_req` 0 and `pc` frozen both cycles; fetch resumes one cycle after release with the same `pc`.
- `pc` = 0xFFFFFFFC, ack → `pc` = 0x0. Separately: `reset_n` pulsed low mid-FETCH with pending redirect → `pc` = `RESET_PC`, pending discarded.
- With the macro defined, jr to 0x402 → `misaligned` pulses, `pc` advances to PC+4. Without the macro → `pc` = 0x400.
